// File: rtl/game_pkg.sv
// ============================================================================
// Module   : game_pkg
// Purpose  : Shared play-field geometry and car start positions.
// Revision : 1.0
// ============================================================================
`default_nettype none

package game_pkg;

   localparam int NUM_COLS       = 20;
   localparam int NUM_ROWS       = 15;
   localparam int CELL           = 32;
   localparam int NUM_CARS       = 16;
   localparam int NUM_LANES      = 8;
   localparam int FIRST_LANE_ROW = 3;
   localparam int COL_W          = 5;
   localparam int ROW_W          = 4;

   typedef logic [COL_W-1:0] col_t;
   typedef logic [ROW_W-1:0] row_t;

   // Partner car sits half a screen behind its lane's lead car.
   function automatic col_t start_x(input int lane, input logic partner);
      int v;
      v = 3 * lane + (partner ? 10 : 0);
      return col_t'(v % NUM_COLS);
   endfunction

endpackage

`default_nettype wire

// File: rtl/traffic_controller_if.sv
// ============================================================================
// Module   : traffic_controller_if
// Purpose  : Game-FSM / traffic-controller control and car-position bundle.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface traffic_controller_if;

   logic        frame_tick;
   logic        run;
   logic        restart;
   logic [1:0]  level;
   logic [4:0]  frog_col;
   logic [3:0]  frog_row;
   logic [79:0] car_x;
   logic [63:0] car_y;
   logic        hit;
   logic        moved;

   modport master (
      output frame_tick, run, restart, level, frog_col, frog_row,
      input  car_x, car_y, hit, moved
   );

   modport slave (
      input  frame_tick, run, restart, level, frog_col, frog_row,
      output car_x, car_y, hit, moved
   );

endinterface

`default_nettype wire

// File: rtl/traffic_lane.sv
// ============================================================================
// Module   : traffic_lane
// Purpose  : One lane: frame-period counter and the x positions of its two cars.
// Revision : 1.0
// ============================================================================
`default_nettype none

module traffic_lane
   import game_pkg::*;
#(
   parameter int LANE        = 0,
   parameter int BASE_PERIOD = 12,
   parameter int PERIOD_STEP = 4,
   parameter int LEVEL_STEP  = 3
) (
   input  wire logic       clk,
   input  wire logic       rst_n,
   input  wire logic       i_frame_tick,
   input  wire logic       i_run,
   input  wire logic       i_restart,
   input  wire logic [1:0] i_level,
   output col_t            o_x_lead,
   output col_t            o_x_partner,
   output row_t            o_y,
   output logic            o_step
);

   localparam col_t       c_START_LEAD    = start_x(LANE, 1'b0);
   localparam col_t       c_START_PARTNER = start_x(LANE, 1'b1);
   localparam row_t       c_ROW           = row_t'(FIRST_LANE_ROW + LANE);
   localparam logic [5:0] c_BASE          = 6'(BASE_PERIOD + (LANE % 4) * PERIOD_STEP);
   localparam logic [5:0] c_LVL           = 6'(LEVEL_STEP);
   localparam col_t       c_LAST          = col_t'(NUM_COLS - 1);
   localparam bit         c_RIGHT         = ((LANE % 2) == 0);

   logic [5:0] r_cnt;
   col_t       r_x_lead;
   col_t       r_x_partner;
   row_t       r_y;
   logic [5:0] w_sub;
   logic [5:0] w_period;
   logic       w_adv;

   // Base <= level reduction means the 6-bit difference would be < 1: clamp.
   assign w_sub    = {4'd0, i_level} * c_LVL;
   assign w_period = (c_BASE > w_sub) ? (c_BASE - w_sub) : 6'd1;
   assign w_adv    = i_frame_tick & i_run & ~i_restart;
   assign o_step   = w_adv & (r_cnt >= (w_period - 6'd1));

   function automatic col_t next_x(input col_t x);
      if (c_RIGHT) begin
         return (x == c_LAST) ? col_t'(0) : x + col_t'(1);
      end
      return (x == col_t'(0)) ? c_LAST : x - col_t'(1);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_x_lead    <= c_START_LEAD;
         r_x_partner <= c_START_PARTNER;
         r_y         <= c_ROW;
      end else if (i_restart) begin
         r_cnt       <= '0;
         r_x_lead    <= c_START_LEAD;
         r_x_partner <= c_START_PARTNER;
      end else if (w_adv) begin
         if (o_step) begin
            r_cnt       <= '0;
            r_x_lead    <= next_x(r_x_lead);
            r_x_partner <= next_x(r_x_partner);
         end else begin
            r_cnt <= r_cnt + 6'd1;
         end
      end
   end

   assign o_x_lead    = r_x_lead;
   assign o_x_partner = r_x_partner;
   assign o_y         = r_y;

endmodule

`default_nettype wire

// File: rtl/traffic_controller.sv
// ============================================================================
// Module   : traffic_controller
// Purpose  : Eight-lane car mover with packed positions, move pulse and frog hit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module traffic_controller
   import game_pkg::*;
#(
   parameter int BASE_PERIOD = 12,
   parameter int PERIOD_STEP = 4,
   parameter int LEVEL_STEP  = 3
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   traffic_controller_if.slave bus
);

   logic [79:0]          w_car_x;
   logic [63:0]          w_car_y;
   logic [NUM_LANES-1:0] w_step;
   logic [NUM_CARS-1:0]  w_match;
   logic                 r_hit;
   logic                 r_moved;

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      traffic_lane #(
         .LANE        (l),
         .BASE_PERIOD (BASE_PERIOD),
         .PERIOD_STEP (PERIOD_STEP),
         .LEVEL_STEP  (LEVEL_STEP)
      ) u_lane (
         .clk          (clk),
         .rst_n        (rst_n),
         .i_frame_tick (bus.frame_tick),
         .i_run        (bus.run),
         .i_restart    (bus.restart),
         .i_level      (bus.level),
         .o_x_lead     (w_car_x[10*l +: 5]),
         .o_x_partner  (w_car_x[10*l+5 +: 5]),
         .o_y          (w_car_y[8*l +: 4]),
         .o_step       (w_step[l])
      );
      assign w_car_y[8*l+4 +: 4] = w_car_y[8*l +: 4];
   end

   // Car coordinates are always in range, so off-grid frog positions never match.
   for (genvar k = 0; k < NUM_CARS; k++) begin : g_match
      assign w_match[k] = (w_car_x[5*k +: 5] == bus.frog_col) &&
                          (w_car_y[4*k +: 4] == bus.frog_row);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hit   <= 1'b0;
         r_moved <= 1'b0;
      end else begin
         r_hit   <= |w_match;
         r_moved <= |w_step;
      end
   end

   assign bus.car_x = w_car_x;
   assign bus.car_y = w_car_y;
   assign bus.hit   = r_hit;
   assign bus.moved = r_moved;

endmodule

`default_nettype wire

// File: tb/tb_traffic_controller.sv
// ============================================================================
// Module   : tb_traffic_controller
// Purpose  : Directed self-checking bench for traffic_controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_traffic_controller;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;
   int   moved_cnt;

   traffic_controller_if bus ();

   traffic_controller dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [4:0] cx(input int k);
      return bus.car_x[5*k +: 5];
   endfunction

   function automatic logic [3:0] cy(input int k);
      return bus.car_y[4*k +: 4];
   endfunction

   function automatic logic [4:0] start_of(input int k);
      int v;
      v = (3 * (k / 2) + (k % 2) * 10) % 20;
      return 5'(v);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Tick is sampled at the posedge between the two negedges; results visible on return.
   task automatic tick();
      @(negedge clk);
      bus.frame_tick = 1'b1;
      @(negedge clk);
      bus.frame_tick = 1'b0;
   endtask

   task automatic do_restart();
      @(negedge clk);
      bus.restart = 1'b1;
      @(negedge clk);
      bus.restart = 1'b0;
   endtask

   initial begin
      n_checks        = 0;
      n_fail          = 0;
      rst_n           = 1'b0;
      bus.frame_tick  = 1'b0;
      bus.run         = 1'b1;
      bus.restart     = 1'b0;
      bus.level       = 2'd0;
      bus.frog_col    = 5'd0;
      bus.frog_row    = 4'd0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      check("rst_x0", 32'(cx(0)), 0);
      check("rst_x1", 32'(cx(1)), 10);
      check("rst_x2", 32'(cx(2)), 3);
      check("rst_x3", 32'(cx(3)), 13);
      check("rst_x14", 32'(cx(14)), 1);
      check("rst_x15", 32'(cx(15)), 11);
      check("rst_y0", 32'(cy(0)), 3);
      check("rst_y15", 32'(cy(15)), 10);
      check("rst_hit", 32'(bus.hit), 0);
      check("rst_moved", 32'(bus.moved), 0);

      // Level 0: lanes 0/4 period 12, lane 1 period 16
      moved_cnt = 0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         moved_cnt += int'(bus.moved);
         if (i == 11) check("x0_before12", 32'(cx(0)), 0);
         if (i == 12) check("moved_t12", 32'(bus.moved), 1);
      end
      check("moved_once", 32'(moved_cnt), 1);
      check("x0_t12", 32'(cx(0)), 1);
      check("x1_t12", 32'(cx(1)), 11);
      check("x2_t12", 32'(cx(2)), 3);
      check("x8_t12", 32'(cx(8)), 13);
      @(negedge clk);
      check("moved_pulse_end", 32'(bus.moved), 0);
      repeat (4) tick();
      check("x2_t16", 32'(cx(2)), 2);
      check("x3_t16", 32'(cx(3)), 12);

      // run=0 freezes positions and counters
      bus.run   = 1'b0;
      moved_cnt = 0;
      repeat (50) begin
         tick();
         moved_cnt += int'(bus.moved);
      end
      check("frz_moved", 32'(moved_cnt), 0);
      check("frz_x0", 32'(cx(0)), 1);
      check("frz_x2", 32'(cx(2)), 2);
      bus.run = 1'b1;
      repeat (7) tick();
      check("resume_x0_7", 32'(cx(0)), 1);
      tick();
      check("resume_x0_8", 32'(cx(0)), 2);
      check("x4_t24", 32'(cx(4)), 7);
      check("x6_t24", 32'(cx(6)), 8);
      check("x8_t24", 32'(cx(8)), 14);

      // restart wins over a simultaneous frame_tick
      @(negedge clk);
      bus.restart    = 1'b1;
      bus.frame_tick = 1'b1;
      @(negedge clk);
      bus.restart    = 1'b0;
      bus.frame_tick = 1'b0;
      for (int k = 0; k < 16; k++) check($sformatf("rs_x%0d", k), 32'(cx(k)), 32'(start_of(k)));
      check("rs_moved", 32'(bus.moved), 0);
      check("rs_y15", 32'(cy(15)), 10);

      // Level 3: periods 3/7/11/15 for lanes 0..3; counters must start at 0
      bus.level = 2'd3;
      for (int i = 1; i <= 15; i++) begin
         tick();
         if (i == 2)  check("l3_x0_2", 32'(cx(0)), 0);
         if (i == 3)  check("l3_x0_3", 32'(cx(0)), 1);
         if (i == 6)  check("l3_x0_6", 32'(cx(0)), 2);
         if (i == 10) check("l3_x4_10", 32'(cx(4)), 6);
         if (i == 11) check("l3_x4_11", 32'(cx(4)), 7);
         if (i == 14) check("l3_x6_14", 32'(cx(6)), 9);
         if (i == 15) check("l3_x6_15", 32'(cx(6)), 8);
      end
      check("l3_x2_15", 32'(cx(2)), 1);

      // Raise level mid-count: lane 3 at cnt 20 steps on the next tick
      do_restart();
      bus.level = 2'd0;
      repeat (20) tick();
      check("mid_x6_20", 32'(cx(6)), 9);
      check("mid_x0_20", 32'(cx(0)), 1);
      bus.level = 2'd3;
      tick();
      check("mid_x6_21", 32'(cx(6)), 8);
      check("mid_x0_21", 32'(cx(0)), 2);
      check("mid_moved", 32'(bus.moved), 1);

      // Wrap-around at level 3
      do_restart();
      for (int i = 1; i <= 98; i++) begin
         tick();
         if (i == 27) check("wrap_x1_19", 32'(cx(1)), 19);
         if (i == 30) check("wrap_x1_0", 32'(cx(1)), 0);
         if (i == 91) check("wrap_x3_0", 32'(cx(3)), 0);
         if (i == 98) check("wrap_x3_19", 32'(cx(3)), 19);
      end

      // Collision
      do_restart();
      check("col_hit_idle", 32'(bus.hit), 0);
      bus.frog_col = 5'd3;
      bus.frog_row = 4'd4;
      #1;
      check("col_hit_latency", 32'(bus.hit), 0);
      @(negedge clk);
      check("col_hit_lead", 32'(bus.hit), 1);
      bus.frog_row = 4'd2;
      #1;
      check("col_hit_hold", 32'(bus.hit), 1);
      @(negedge clk);
      check("col_hit_clear", 32'(bus.hit), 0);
      bus.frog_col = 5'd13;
      bus.frog_row = 4'd4;
      @(negedge clk);
      check("col_hit_partner", 32'(bus.hit), 1);
      bus.frog_col = 5'd20;
      bus.frog_row = 4'd3;
      @(negedge clk);
      check("col_oob_col", 32'(bus.hit), 0);
      bus.frog_col = 5'd10;
      bus.frog_row = 4'd3;
      @(negedge clk);
      check("col_hit_l0p", 32'(bus.hit), 1);

      // Asynchronous reset between clock edges
      bus.frog_col = 5'd3;
      bus.frog_row = 4'd4;
      repeat (3) tick();
      check("ar_pre_moved", 32'(bus.moved), 1);
      check("ar_pre_x0", 32'(cx(0)), 1);
      check("ar_pre_hit", 32'(bus.hit), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_moved", 32'(bus.moved), 0);
      check("ar_hit", 32'(bus.hit), 0);
      check("ar_x0", 32'(cx(0)), 0);
      check("ar_x5", 32'(cx(5)), 16);
      check("ar_y0", 32'(cy(0)), 3);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("ar_hit_after", 32'(bus.hit), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
